// File: rtl/toy_dmem_responder.sv
// Data-memory responder for the RISC_TOY data port: word RAM, a 4-register MMIO window
// (cycle counter, scratch, halt, error address) and a fixed-latency pipelined read path.
module toy_dmem_responder #(
    parameter int unsigned AW        = 10,
    parameter int unsigned ENTRY     = 1024,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [29:0] MMIO_BASE = 30'h3FFFFF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic        DVALID,
    output logic        HALT,
    output logic        ERR
);

    localparam logic [31:0] UnmappedData = 32'hDEADBEEF;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("toy_dmem_responder: RD_LAT must be in 1..4");
    end
    if (ENTRY > (1 << AW)) begin : g_bad_entry
        $error("toy_dmem_responder: ENTRY exceeds 2**AW");
    end

    logic [31:0]   mem [ENTRY];

    logic          ram_hit;
    logic          mmio_hit;
    logic          unmapped;
    logic [29:0]   mmio_delta;
    logic [1:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic [31:0]   rd_data;

    logic [31:0]   cycle_q;
    logic [31:0]   scratch_q;
    logic [31:0]   erraddr_q;
    logic          halt_q;
    logic          err_q;

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_in;
    logic [31:0]       dat_q  [RD_LAT];
    logic [31:0]       dat_in [RD_LAT];

    // Address decode; the delta form keeps the MMIO upper bound free of overflow.
    always_comb begin
        ram_hit    = ({2'b00, DADDR} < ENTRY);
        mmio_delta = DADDR - MMIO_BASE;
        mmio_hit   = (DADDR >= MMIO_BASE) && (mmio_delta < 30'd4);
        mmio_off   = mmio_delta[1:0];
        unmapped   = !ram_hit && !mmio_hit;
        ram_idx    = DADDR[AW-1:0];
    end

    // Read data is captured at acceptance, so it reflects state before this edge's updates.
    always_comb begin
        rd_data = UnmappedData;
        if (ram_hit) begin
            rd_data = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                2'd0:    rd_data = cycle_q;
                2'd1:    rd_data = scratch_q;
                2'd2:    rd_data = {31'b0, halt_q};
                default: rd_data = erraddr_q;
            endcase
        end
    end

    always_comb begin
        vld_in    = '0;
        vld_in[0] = DREQ && !DRW;
        dat_in[0] = rd_data;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_in[i] = vld_q[i-1];
            dat_in[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && DREQ && DRW && ram_hit) begin
            mem[ram_idx] <= DWDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_q   <= '0;
            scratch_q <= '0;
            erraddr_q <= '0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (DREQ) begin
                if (DRW && mmio_hit) begin
                    if (mmio_off == 2'd1) begin
                        scratch_q <= DWDATA;
                    end
                    if (mmio_off == 2'd2 && DWDATA[0]) begin
                        halt_q <= 1'b1;
                    end
                end
                if (unmapped) begin
                    err_q     <= 1'b1;
                    erraddr_q <= {2'b00, DADDR};
                end
            end
            vld_q <= vld_in;
            // Data stages only load on a valid beat, so the last stage holds the last read.
            for (int i = 0; i < int'(RD_LAT); i++) begin
                if (vld_in[i]) begin
                    dat_q[i] <= dat_in[i];
                end
            end
        end
    end

    assign DRDATA = dat_q[RD_LAT-1];
    assign DVALID = vld_q[RD_LAT-1];
    assign HALT   = halt_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Directed bench for toy_dmem_responder: three instances (RD_LAT 1, 2, 3) share one stimulus
// stream and are checked against hand-computed values with immediate assertions.
module tb_toy_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dreq;
    logic        drw;
    logic [29:0] daddr;
    logic [31:0] dwdata;

    logic [31:0] d1, d2, d3;
    logic        v1, v2, v3;
    logic        h1, h2, h3;
    logic        e1, e2, e3;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [29:0] ACycle   = 30'h3FFFFF00;
    localparam logic [29:0] AScratch = 30'h3FFFFF01;
    localparam logic [29:0] AHalt    = 30'h3FFFFF02;
    localparam logic [29:0] AErrAddr = 30'h3FFFFF03;

    always #5 clk = ~clk;

    toy_dmem_responder #(.RD_LAT(1)) u_lat1 (
        .CLK(clk), .RST(rst), .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
        .DRDATA(d1), .DVALID(v1), .HALT(h1), .ERR(e1)
    );
    toy_dmem_responder #(.RD_LAT(2)) u_lat2 (
        .CLK(clk), .RST(rst), .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
        .DRDATA(d2), .DVALID(v2), .HALT(h2), .ERR(e2)
    );
    toy_dmem_responder #(.RD_LAT(3)) u_lat3 (
        .CLK(clk), .RST(rst), .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
        .DRDATA(d3), .DVALID(v3), .HALT(h3), .ERR(e3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [29:0] addr, input logic [31:0] data);
        dreq = 1'b1; drw = 1'b1; daddr = addr; dwdata = data;
        step();
        dreq = 1'b0;
    endtask

    // Issues one read and checks each instance's single DVALID beat at its own latency.
    task automatic rd_check(input logic [29:0] addr, input logic [31:0] exp, input string tag);
        dreq = 1'b1; drw = 1'b0; daddr = addr;
        for (int k = 0; k < 3; k++) begin
            step();
            dreq = 1'b0;
            case (k)
                0: begin
                    chk({tag, " v1"}, {31'b0, v1}, 32'd1);
                    chk({tag, " d1"}, d1, exp);
                    chk({tag, " v2 early"}, {31'b0, v2}, 32'd0);
                end
                1: begin
                    chk({tag, " v1 pulse"}, {31'b0, v1}, 32'd0);
                    chk({tag, " v2"}, {31'b0, v2}, 32'd1);
                    chk({tag, " d2"}, d2, exp);
                end
                default: begin
                    chk({tag, " v3"}, {31'b0, v3}, 32'd1);
                    chk({tag, " d3"}, d3, exp);
                    chk({tag, " v2 pulse"}, {31'b0, v2}, 32'd0);
                end
            endcase
        end
    endtask

    function automatic logic [31:0] dat_of(input int l);
        return (l == 1) ? d1 : (l == 2) ? d2 : d3;
    endfunction

    function automatic logic val_of(input int l);
        return (l == 1) ? v1 : (l == 2) ? v2 : v3;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ev;
        logic [31:0] ed;

        rst = 1'b1; dreq = 1'b0; drw = 1'b0; daddr = '0; dwdata = '0;
        step();
        step();
        chk("rst d1", d1, 32'd0);
        chk("rst d2", d2, 32'd0);
        chk("rst d3", d3, 32'd0);
        chk("rst valid", {29'b0, v1, v2, v3}, 32'd0);
        chk("rst halt", {29'b0, h1, h2, h3}, 32'd0);
        chk("rst err", {29'b0, e1, e2, e3}, 32'd0);
        rst = 1'b0;

        // RAM write then read-after-write on the next cycle.
        wr(30'd5, 32'h12345678);
        dreq = 1'b1; drw = 1'b0; daddr = 30'd5;
        step();
        dreq = 1'b0;
        chk("raw v1", {31'b0, v1}, 32'd1);
        chk("raw d1", d1, 32'h12345678);
        chk("raw v2 early", {31'b0, v2}, 32'd0);
        chk("raw err", {31'b0, e1}, 32'd0);
        step();
        chk("raw v1 off", {31'b0, v1}, 32'd0);
        chk("raw d1 hold", d1, 32'h12345678);
        chk("raw v2", {31'b0, v2}, 32'd1);
        chk("raw d2", d2, 32'h12345678);
        step();
        chk("raw v3", {31'b0, v3}, 32'd1);
        chk("raw d3", d3, 32'h12345678);

        // Four back-to-back reads; instance L pulses on steps L-1 .. L+2.
        for (int i = 0; i < 4; i++) wr(30'(i), 32'(10 + i));
        wr(30'd952, 32'h0BAD0952);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                dreq = 1'b1; drw = 1'b0; daddr = 30'(k);
            end else begin
                dreq = 1'b0;
            end
            step();
            for (int l = 1; l <= 3; l++) begin
                ev = (k >= l - 1) && (k <= l + 2);
                ed = (k < l - 1) ? 32'h12345678 : (ev ? 32'(10 + k - l + 1) : 32'd13);
                chk($sformatf("pipe v L%0d k%0d", l, k), {31'b0, val_of(l)}, {31'b0, ev});
                chk($sformatf("pipe d L%0d k%0d", l, k), dat_of(l), ed);
            end
        end

        // MMIO scratch, halt, read-only cycle.
        wr(AScratch, 32'hA5A5A5A5);
        rd_check(AScratch, 32'hA5A5A5A5, "scratch");
        chk("halt pre", {31'b0, h1}, 32'd0);
        wr(AHalt, 32'h00000001);
        chk("halt set", {31'b0, h1}, 32'd1);
        wr(AHalt, 32'hFFFFFFFE);
        chk("halt sticky", {29'b0, h1, h2, h3}, 32'd7);
        rd_check(AHalt, 32'd1, "halt rd");
        wr(ACycle, 32'hFFFFFFFF);
        chk("cycle wr err", {31'b0, e1}, 32'd0);

        // Unmapped read and write.
        rd_check(30'd2000, 32'hDEADBEEF, "unmapped rd");
        chk("unmapped err", {29'b0, e1, e2, e3}, 32'd7);
        rd_check(AErrAddr, 32'd2000, "erraddr1");
        wr(30'd3000, 32'hCAFEF00D);
        rd_check(AErrAddr, 32'd3000, "erraddr2");
        rd_check(30'd952, 32'h0BAD0952, "alias intact");
        chk("err sticky", {31'b0, e1}, 32'd1);

        // Reset with a read in flight.
        dreq = 1'b1; drw = 1'b0; daddr = 30'd5;
        step();
        rst = 1'b1; dreq = 1'b0;
        step();
        chk("mid rst valid", {29'b0, v1, v2, v3}, 32'd0);
        chk("mid rst d1", d1, 32'd0);
        chk("mid rst d2", d2, 32'd0);
        chk("mid rst d3", d3, 32'd0);
        chk("mid rst halt", {29'b0, h1, h2, h3}, 32'd0);
        chk("mid rst err", {29'b0, e1, e2, e3}, 32'd0);
        rst = 1'b0;
        step();
        chk("flushed valid", {29'b0, v1, v2, v3}, 32'd0);
        for (int i = 1; i < 7; i++) step();
        chk("flushed d3", d3, 32'd0);

        // Cycle counter: edges counted from reset release; writes to 0 and 3 are dropped.
        rd_check(ACycle, 32'd7, "cycle7");
        wr(ACycle, 32'h00000000);
        wr(AErrAddr, 32'h00001234);
        for (int i = 12; i < 17; i++) step();
        rd_check(ACycle, 32'd17, "cycle17");
        chk("ro wr err", {31'b0, e1}, 32'd0);
        rd_check(AErrAddr, 32'd0, "erraddr ro");
        rd_check(30'd5, 32'h12345678, "ram kept");

        // Counter wrap on the latency-1 instance.
        force u_lat1.cycle_q = 32'hFFFFFFFF;
        #1;
        release u_lat1.cycle_q;
        dreq = 1'b1; drw = 1'b0; daddr = ACycle;
        step();
        chk("wrap pre", d1, 32'hFFFFFFFF);
        step();
        dreq = 1'b0;
        chk("wrap zero", d1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
